pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the PC enable and the enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three events: load-use hazards, taken-branch flushes, and multi-cycle data-memory waits via a req/ready handshake.
- Includes a wait watchdog and a saturating stall-cycle counter.

Parameters:
- REG_W, 5: register-specifier width.
- MAX_WAIT, 16: maximum dmem wait cycles before the error trap. Legal range is 2..65535.
- CNT_W, 16: width of the stall counter.

Ports:
- clk in 1: rising-edge clock.
- rst in 1: asynchronous, active-high reset.
- id_rs in REG_W: rs field of the instruction in ID.
- id_rt in REG_W: rt field of the instruction in ID.
- idex_memread in 1: the instruction in EX is a load.
- idex_rt in REG_W: destination register of that load.
- ex_branch_taken in 1: branch resolved taken in EX.
- exmem_memop in 1: the instruction in MEM is a load or store.
- dmem_ready in 1: data memory completes the access this cycle.
- pc_en out 1: PC update enable.
- ifid_en out 1: IF/ID register enable.
- ifid_flush out 1: IF/ID register flush.
- idex_en out 1: ID/EX register enable.
- idex_flush out 1: ID/EX register flush.
- exmem_en out 1: EX/MEM register enable.
- memwb_en out 1: MEM/WB register enable.
- memwb_bubble out 1: load a bubble into MEM/WB (RegWrite=0, MemtoReg=0).
- dmem_req out 1: data-memory request.
- stall_cnt out CNT_W: total stall cycles, saturating.
- err out 1: watchdog trap flag, sticky.

Behaviour:
- Registered state: fsm (RUN, MEM_WAIT, ERR), wait_cnt (16 bits), stall_cnt, err. All other outputs are combinational from state and inputs, with zero latency.
- Reset (async, while rst=1): fsm=RUN, wait_cnt=0, stall_cnt=0, err=0. Outputs are forced to: all *_en=0, ifid_flush=1, idex_flush=1, memwb_bubble=1, dmem_req=0.
- load_use = idex_memread & (idex_rt≠0) & (idex_rt==id_rs | idex_rt==id_rt).
- mem_stall = exmem_memop & ~dmem_ready.
- RUN defaults: all *_en=1, flushes=0, memwb_bubble=0, dmem_req=exmem_memop.
- RUN priority 1, mem_stall: next state MEM_WAIT. Outputs: all *_en=0, memwb_bubble=1, ifid_flush=0, idex_flush=0. Branch and load-use are ignored this cycle; they re-evaluate on release because the pipeline is frozen. wait_cnt←1.
- RUN priority 2, ex_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1. Load-use is ignored because the ID instruction is squashed.
- RUN priority 3, load_use: pc_en=0, ifid_en=0, idex_flush=1. EX/MEM and MEM/WB continue.
- MEM_WAIT: dmem_req=1, all *_en=0, memwb_bubble=1, no flushes.
  - dmem_ready=1: next state RUN. Outputs this cycle follow the RUN rules with mem_stall=0, so the pipeline advances in the same cycle.
  - Otherwise, if wait_cnt==MAX_WAIT-1: next state ERR. Otherwise wait_cnt increments.
  - exmem_memop is held by the frozen EX/MEM register. Its deassertion while in MEM_WAIT is an illegal input and does not need to be handled.
- ERR: err=1, all *_en=0, memwb_bubble=1, dmem_req=0, no flushes. Only rst exits this state.
- stall_cnt increments by 1 in every cycle where pc_en=0 and fsm≠ERR. It saturates at all-ones and never wraps.
- A reset asserted mid-wait aborts the access immediately: dmem_req drops asynchronously.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum typedef (RUN, MEM_WAIT, ERR);
  - REG_W;
  - the zero-register constant ZERO_REG=0.
- One natural sub-module: hazard_detect. It is purely combinational: it takes the id/idex fields and outputs load_use. The same unit is reused by a future forwarding unit.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, id_rs=5 for one cycle. Required: pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt goes 0→1. Repeating with idex_rt=0 gives no stall.
- Branch flush: ex_branch_taken=1 with load_use also true. Required: pc_en=1, ifid_flush=1, idex_flush=1; stall_cnt unchanged.
- Memory wait: exmem_memop=1, dmem_ready held low 3 cycles, then high. Required: 3 frozen cycles with memwb_bubble=1 and dmem_req=1; all *_en=1 on the ready cycle; stall_cnt=3.
- Zero-wait access: exmem_memop=1 and dmem_ready=1 in the same cycle. Required: no freeze, dmem_req=1, fsm stays RUN.
- Watchdog: MAX_WAIT=4, dmem_ready never asserts. Required: err=1 after 4 frozen cycles. err stays 1 and pipeline stays frozen despite dmem_ready; reset clears err to 0.
- Async reset mid-wait plus saturation:
  - Reset mid-wait: assert rst between clock edges during MEM_WAIT. Required: dmem_req=0 and fsm=RUN immediately.
  - Saturation (CNT_W=4): 20 stalled cycles. Required: stall_cnt=15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline control types and constants.
// Imported by the hazard sequencer and the detect unit.
package pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } fsm_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/ready handshake.
// The master issues requests; the memory side answers with ready.
interface pipe_hazard_ctrl_if;

    logic dmem_req;
    logic dmem_ready;

    modport master (
        output dmem_req,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        output dmem_ready
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection between the ID and EX stages.
// Purely combinational so it can be shared with forwarding logic.
module hazard_detect #(
    parameter int REG_W = pipe_pkg::REG_W
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    output logic             load_use
);

    import pipe_pkg::*;

    logic rt_live;
    logic rt_hit;

    assign rt_live = idex_rt != REG_W'(ZERO_REG);
    assign rt_hit  = (idex_rt == id_rs)
                   | (idex_rt == id_rt);

    assign load_use = idex_memread
                    & rt_live
                    & rt_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use, taken branch and dmem waits with a watchdog.
module pipe_hazard_ctrl #(
    parameter int REG_W    = pipe_pkg::REG_W,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             ex_branch_taken,
    input  logic             exmem_memop,
    pipe_hazard_ctrl_if.master dmem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    import pipe_pkg::*;

    localparam logic [15:0] WAIT_LAST =
        16'(MAX_WAIT - 1);

    fsm_e             fsm_q, fsm_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic load_use;
    logic mem_stall;
    logic use_run;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .load_use     (load_use)
    );

    assign mem_stall = exmem_memop & ~dmem.dmem_ready;

    // A ready beat in MEM_WAIT releases the pipe in the same cycle.
    assign use_run = (fsm_q == RUN)
                   | ((fsm_q == MEM_WAIT) & dmem.dmem_ready);

    always_comb begin
        fsm_d  = fsm_q;
        wait_d = wait_q;
        err_d  = err_q;

        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_bubble  = 1'b0;
        dmem.dmem_req = exmem_memop;

        if (use_run) begin
            if (fsm_q == MEM_WAIT) begin
                fsm_d  = RUN;
                wait_d = '0;
            end
            if (mem_stall) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_en     = 1'b0;
                memwb_bubble = 1'b1;
                fsm_d        = MEM_WAIT;
                wait_d       = 16'd1;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end else begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
            if (fsm_q == MEM_WAIT) begin
                dmem.dmem_req = 1'b1;
                if (wait_q == WAIT_LAST) begin
                    fsm_d = ERR;
                    err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end else begin
                dmem.dmem_req = 1'b0;
                err_d         = 1'b1;
            end
        end

        cnt_d = cnt_q;
        if (!pc_en && fsm_q != ERR && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);

        // Reset forces a safe frozen, flushed pipe and aborts dmem.
        if (rst) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_en       = 1'b0;
            exmem_en      = 1'b0;
            memwb_en      = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            memwb_bubble  = 1'b1;
            dmem.dmem_req = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= RUN;
            wait_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            wait_q <= wait_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign stall_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl.
// Small watchdog and counter widths exercise both limits.
module tb_pipe_hazard_ctrl;

    import pipe_pkg::*;

    localparam int RW = 5;
    localparam int CW = 4;

    // {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem,memwb,bub,req}
    localparam logic [8:0] C_RST  = 9'b001010010;
    localparam logic [8:0] C_RUN  = 9'b110101100;
    localparam logic [8:0] C_RUNQ = 9'b110101101;
    localparam logic [8:0] C_LU   = 9'b000111100;
    localparam logic [8:0] C_BR   = 9'b111111100;
    localparam logic [8:0] C_FRZ  = 9'b000000011;
    localparam logic [8:0] C_ERR  = 9'b000000010;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] id_rs = '0;
    logic [RW-1:0] id_rt = '0;
    logic          idex_memread = 1'b0;
    logic [RW-1:0] idex_rt = '0;
    logic          ex_branch_taken = 1'b0;
    logic          exmem_memop = 1'b0;
    logic          pc_en, ifid_en, ifid_flush;
    logic          idex_en, idex_flush;
    logic          exmem_en, memwb_en, memwb_bubble;
    logic [CW-1:0] stall_cnt;
    logic          err;
    logic [8:0]    ctl;

    int n_vec = 0;
    int n_bad = 0;

    pipe_hazard_ctrl_if dmem ();

    pipe_hazard_ctrl #(
        .REG_W    (RW),
        .MAX_WAIT (4),
        .CNT_W    (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .exmem_memop     (exmem_memop),
        .dmem            (dmem.master),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .memwb_bubble    (memwb_bubble),
        .stall_cnt       (stall_cnt),
        .err             (err)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, ifid_flush,
                  idex_en, idex_flush, exmem_en,
                  memwb_en, memwb_bubble,
                  dmem.dmem_req};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h",
                     tag, got, exp);
        end
    endtask

    // Advance one edge; settle inputs/outputs away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        idex_memread    = 1'b0;
        idex_rt         = '0;
        id_rs           = '0;
        id_rt           = '0;
        ex_branch_taken = 1'b0;
        exmem_memop     = 1'b0;
        dmem.dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clr();
        #1;
        chk("rst_ctl0", 32'(ctl), 32'(C_RST));
        chk("rst_err0", 32'(err), 0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("idle_ctl", 32'(ctl), 32'(C_RUN));

        // load-use on rs
        idex_memread = 1'b1;
        idex_rt      = 5'd5;
        id_rs        = 5'd5;
        #1;
        chk("lu_ctl", 32'(ctl), 32'(C_LU));
        step();
        clr();
        #1;
        chk("lu_cnt", 32'(stall_cnt), 1);

        // load into r0 never stalls
        idex_memread = 1'b1;
        id_rs        = 5'd0;
        #1;
        chk("lu0_ctl", 32'(ctl), 32'(C_RUN));
        step();
        clr();
        #1;
        chk("lu0_cnt", 32'(stall_cnt), 1);

        // branch overrides load-use on rt
        idex_memread    = 1'b1;
        idex_rt         = 5'd7;
        id_rt           = 5'd7;
        ex_branch_taken = 1'b1;
        #1;
        chk("br_ctl", 32'(ctl), 32'(C_BR));
        step();
        clr();
        #1;
        chk("br_cnt", 32'(stall_cnt), 1);

        // three-cycle memory wait
        do_reset();
        exmem_memop = 1'b1;
        #1;
        chk("mw_ctl0", 32'(ctl), 32'(C_FRZ));
        for (int i = 1; i < 3; i++) begin
            step();
            chk($sformatf("mw_ctl%0d", i),
                32'(ctl), 32'(C_FRZ));
        end
        step();
        dmem.dmem_ready = 1'b1;
        #1;
        chk("mw_rel", 32'(ctl), 32'(C_RUNQ));
        step();
        clr();
        #1;
        chk("mw_cnt", 32'(stall_cnt), 3);
        chk("mw_fsm", 32'(dut.fsm_q), 32'(RUN));

        // zero-wait access
        exmem_memop     = 1'b1;
        dmem.dmem_ready = 1'b1;
        #1;
        chk("zw_ctl", 32'(ctl), 32'(C_RUNQ));
        step();
        chk("zw_fsm", 32'(dut.fsm_q), 32'(RUN));
        chk("zw_cnt", 32'(stall_cnt), 3);
        clr();

        // watchdog trips after four frozen cycles
        do_reset();
        exmem_memop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("wd_frz%0d", i),
                32'(ctl), 32'(C_FRZ));
            chk($sformatf("wd_err%0d", i),
                32'(err), 0);
            step();
        end
        chk("wd_err", 32'(err), 1);
        chk("wd_ctl", 32'(ctl), 32'(C_ERR));
        dmem.dmem_ready = 1'b1;
        #1;
        chk("wd_rdy", 32'(ctl), 32'(C_ERR));
        step();
        chk("wd_hold", 32'(err), 1);
        chk("wd_cnt", 32'(stall_cnt), 4);
        rst = 1'b1;
        #1;
        chk("wd_clr", 32'(err), 0);
        chk("wd_rctl", 32'(ctl), 32'(C_RST));
        step();
        rst = 1'b0;
        clr();
        #1;

        // async reset in the middle of a wait
        exmem_memop = 1'b1;
        step();
        chk("ar_req", 32'(dmem.dmem_req), 1);
        chk("ar_wait", 32'(dut.fsm_q), 32'(MEM_WAIT));
        rst = 1'b1;
        #1;
        chk("ar_req0", 32'(dmem.dmem_req), 0);
        chk("ar_fsm", 32'(dut.fsm_q), 32'(RUN));
        step();
        rst = 1'b0;
        clr();
        #1;

        // counter saturates at all-ones
        idex_memread = 1'b1;
        idex_rt      = 5'd3;
        id_rt        = 5'd3;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", 32'(stall_cnt), 15);
        clr();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=done");
        $fatal(1);
    end

endmodule
